// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output peripheral.
// Widths, the 100 % duty code and the default prescale all live here.
package pwm_pkg;

  localparam int          PWM_W                = 8;
  localparam logic [7:0]  PWM_DUTY_FULL        = 8'hFF;
  localparam int          PWM_PRESCALE_DEFAULT = 13;
  localparam int          NUM_OUT              = 16;

  typedef logic [NUM_OUT-1:0] pin_vec_t;
  typedef logic [PWM_W-1:0]   pwm_word_t;

endpackage

// File: rtl/pwm_if.sv
// Configuration registers from the SPI register block and the pin drive vector.
// The master side owns the configuration; the slave side owns the pin drive.
interface pwm_if;
  import pwm_pkg::*;

  logic [7:0]   en_reg_out_7_0;
  logic [7:0]   en_reg_out_15_8;
  logic [7:0]   en_reg_pwm_7_0;
  logic [7:0]   en_reg_pwm_15_8;
  pwm_word_t    pwm_duty_cycle;
  pin_vec_t     out;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out
  );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit period counter and period-aligned duty shadow.
// Produces the shared unregistered PWM level for all PWM-selected pins.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pwm_word_t duty,
  output logic      pwm_raw
);

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

  logic [7:0] pre_cnt;
  pwm_word_t  pwm_cnt;
  pwm_word_t  duty_q;
  logic       tick;
  logic       wrap;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (pwm_cnt == {PWM_W{1'b1}});

  // Duty is sampled only at the wrap so a mid-period write cannot cut a pulse short or add one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) duty_q  <= duty;
    end
  end

  assign pwm_raw = (duty_q == PWM_DUTY_FULL) || (pwm_cnt < duty_q);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 general-purpose pins as static 0/1 or the shared PWM waveform.
// Per-pin mux is combinational; the pin vector is registered once.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  pwm_if.slave  bus
);

  pin_vec_t en_out;
  pin_vec_t en_pwm;
  pin_vec_t drive_p0;
  pin_vec_t out_p1;
  logic     pwm_raw;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (bus.pwm_duty_cycle),
    .pwm_raw (pwm_raw)
  );

  // Stage p0 -> p1: a PWM select without the matching output enable leaves the pin at 0.
  assign drive_p0 = en_out & (~en_pwm | {NUM_OUT{pwm_raw}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_p1 <= '0;
    else        out_p1 <= drive_p0;
  end

  assign bus.out = out_p1;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: default prescale instance plus a PRESCALE=1 instance.
// Cycle numbers count rising edges after reset release, sampled 1 time unit after each edge.
module tb_pwm_peripheral;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_if bus ();
  pwm_if bus1 ();

  pwm_peripheral dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int trk_bit = 0;
  int hi_cnt = 0;
  logic prev = 1'b0;
  int rises[$];
  int falls[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic track_to(input int stop);
    logic cur;
    while (cyc < stop) begin
      step();
      cur = bus.out[trk_bit];
      if (cur && !prev) rises.push_back(cyc);
      if (!cur && prev) falls.push_back(cyc);
      if (cur) hi_cnt++;
      prev = cur;
    end
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
    bus.pwm_duty_cycle  = d;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_rst_async"}, 32'(bus.out), 32'h0);
    step();
    step();
    check({tag, "_rst_hold"}, 32'(bus.out), 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    prev = 1'b0;
    hi_cnt = 0;
    rises.delete();
    falls.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bus1.en_reg_out_7_0  = 8'h00;
    bus1.en_reg_out_15_8 = 8'h00;
    bus1.en_reg_pwm_7_0  = 8'h00;
    bus1.en_reg_pwm_15_8 = 8'h00;
    bus1.pwm_duty_cycle  = 8'h00;

    // All inputs 0xFF: every pin is PWM, low until the first wrap loads duty 0xFF.
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    #12;
    do_reset("all_ff");
    step();
    check("all_ff_c1", 32'(bus.out), 32'h0);
    trk_bit = 15;
    track_to(3328);
    check("all_ff_prewrap", 32'(bus.out), 32'h0);
    step();
    check("all_ff_postwrap", 32'(bus.out), 32'hFFFF);
    hi_cnt = 0;
    track_to(6662);
    check("all_ff_full_hi", 32'(hi_cnt), 32'd3333);

    // Static outputs, no PWM selects.
    set_cfg(16'h00FF, 16'h0000, 8'h80);
    step();
    check("static_val", 32'(bus.out), 32'h00FF);
    bad = 0;
    for (int i = 0; i < 3 * 3328; i++) begin
      step();
      if (bus.out !== 16'h00FF) bad++;
    end
    check("static_no_toggle", 32'(bad), 32'd0);

    // 50 % duty on pin 0.
    set_cfg(16'h0001, 16'h0001, 8'h80);
    do_reset("half");
    trk_bit = 0;
    track_to(6700);
    check("half_rise0", 32'((rises.size() > 0) ? rises[0] : -1), 32'd3329);
    check("half_fall0", 32'((falls.size() > 0) ? falls[0] : -1), 32'd4993);
    check("half_rise1", 32'((rises.size() > 1) ? rises[1] : -1), 32'd6657);
    check("half_high_time", 32'((rises.size() > 0 && falls.size() > 0) ? falls[0] - rises[0] : -1), 32'd1664);
    check("half_period", 32'((rises.size() > 1) ? rises[1] - rises[0] : -1), 32'd3328);

    // Duty 0 then 0xFF: flat low, then flat high from the next wrap.
    set_cfg(16'h0001, 16'h0001, 8'h00);
    do_reset("zero_full");
    track_to(5000);
    bus.pwm_duty_cycle = 8'hFF;
    track_to(9990);
    check("zf_rise_count", 32'(rises.size()), 32'd1);
    check("zf_rise_at", 32'((rises.size() > 0) ? rises[0] : -1), 32'd6657);
    check("zf_fall_count", 32'(falls.size()), 32'd0);
    check("zf_hi_cycles", 32'(hi_cnt), 32'd3334);

    // Duty 0x40 -> 0xC0 written when pwm_cnt = 0x50.
    set_cfg(16'h0001, 16'h0001, 8'h40);
    do_reset("shadow");
    track_to(4368);
    check("shadow_low_at_write", 32'(bus.out[0]), 32'd0);
    bus.pwm_duty_cycle = 8'hC0;
    track_to(9500);
    check("shadow_rise_count", 32'(rises.size()), 32'd2);
    check("shadow_fall_count", 32'(falls.size()), 32'd2);
    check("shadow_fall0", 32'((falls.size() > 0) ? falls[0] : -1), 32'd4161);
    check("shadow_rise1", 32'((rises.size() > 1) ? rises[1] : -1), 32'd6657);
    check("shadow_fall1", 32'((falls.size() > 1) ? falls[1] : -1), 32'd9153);

    // Pin 15: static 1 -> PWM -> disabled, then async reset mid-period.
    set_cfg(16'h0000, 16'h0000, 8'h80);
    do_reset("pin15");
    trk_bit = 15;
    track_to(10);
    check("p15_off", 32'(bus.out), 32'h0);
    set_cfg(16'h8000, 16'h0000, 8'h80);
    step();
    check("p15_static_on", 32'(bus.out), 32'h8000);
    track_to(3400);
    check("p15_static_hold", 32'(bus.out), 32'h8000);
    set_cfg(16'h8000, 16'h8000, 8'h80);
    track_to(4992);
    check("p15_pwm_hi", 32'(bus.out), 32'h8000);
    step();
    check("p15_pwm_fall", 32'(bus.out), 32'h0);
    track_to(6700);
    check("p15_pwm_rise", 32'(bus.out), 32'h8000);
    set_cfg(16'h0000, 16'h8000, 8'h80);
    step();
    check("p15_sel_only", 32'(bus.out), 32'h0);
    hi_cnt = 0;
    track_to(7000);
    check("p15_sel_only_hold", 32'(hi_cnt), 32'd0);
    set_cfg(16'h8000, 16'h8000, 8'h80);
    step();
    check("p15_reenable", 32'(bus.out), 32'h8000);
    rst_n = 1'b0;
    #2;
    check("p15_async_drop", 32'(bus.out), 32'h0);
    step();
    check("p15_rst_hold", 32'(bus.out), 32'h0);

    // PRESCALE = 1 instance: period 256 clk.
    bus1.en_reg_out_7_0 = 8'h01;
    bus1.en_reg_pwm_7_0 = 8'h01;
    bus1.pwm_duty_cycle = 8'h80;
    do_reset("fast");
    track_to(256);
    check("fast_prewrap", 32'(bus1.out), 32'h0);
    step();
    check("fast_rise", 32'(bus1.out), 32'h1);
    track_to(384);
    check("fast_last_hi", 32'(bus1.out), 32'h1);
    step();
    check("fast_fall", 32'(bus1.out), 32'h0);
    track_to(512);
    check("fast_last_lo", 32'(bus1.out), 32'h0);
    step();
    check("fast_rise2", 32'(bus1.out), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
